// File: rtl/iaf_spike_arbiter.sv
// Round-robin AER arbiter for an iaf neuron array: latches spikes, pulses membrane resets, serializes events.
// Optional build macro IAF_ARB_DROP_COUNT_EN builds the 8-bit saturating drop counter (tied to zero otherwise).
module iaf_spike_arbiter #(
   parameter int NEURONS = 8,
   parameter int ADDR_W  = 3
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic [NEURONS-1:0] spike_in,
   input  logic               clear,
   output logic [NEURONS-1:0] re_out,
   output logic               aer_valid,
   output logic [ADDR_W-1:0]  aer_addr,
   input  logic               aer_ready,
   output logic               overflow,
   output logic [7:0]         drop_count
);

   localparam logic [ADDR_W-1:0] PTR_INIT = ADDR_W'(NEURONS - 1);

   logic [NEURONS-1:0] pending_q, pending_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic               valid_q, valid_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [NEURONS-1:0] re_q, re_d;
   logic               overflow_q, overflow_d;

   logic               slot_free;
   logic               grant;
   logic               hi_found;
   logic [ADDR_W-1:0]  hi_pick, lo_pick, pick;
   logic [NEURONS-1:0] grant_mask;
   logic               any_drop;

   // Two descending scans: lowest index above ptr wins, otherwise lowest index at or below ptr.
   always_comb begin
      hi_found = 1'b0;
      hi_pick  = '0;
      lo_pick  = '0;
      for (int i = NEURONS - 1; i >= 0; i--) begin
         if (pending_q[i] && (i > int'(ptr_q))) begin
            hi_found = 1'b1;
            hi_pick  = ADDR_W'(i);
         end
         if (pending_q[i] && (i <= int'(ptr_q))) begin
            lo_pick = ADDR_W'(i);
         end
      end
      pick = hi_found ? hi_pick : lo_pick;
   end

   always_comb begin
      slot_free = !valid_q || aer_ready;
      grant     = slot_free && (|pending_q);
      for (int j = 0; j < NEURONS; j++) begin
         grant_mask[j] = grant && (pick == ADDR_W'(j));
      end
      any_drop = |(spike_in & pending_q & ~grant_mask);

      pending_d  = (pending_q & ~grant_mask) | spike_in;
      ptr_d      = grant ? pick : ptr_q;
      valid_d    = slot_free ? grant : valid_q;
      addr_d     = grant ? pick : addr_q;
      re_d       = spike_in;
      overflow_d = overflow_q | any_drop;

      if (clear) begin
         pending_d  = '0;
         ptr_d      = PTR_INIT;
         valid_d    = 1'b0;
         re_d       = '1;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         pending_q  <= '0;
         ptr_q      <= PTR_INIT;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         re_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         re_q       <= re_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef IAF_ARB_DROP_COUNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clear) begin
         drop_cnt_d = '0;
      end else if (any_drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = 8'd0;
`endif

   assign re_out    = re_q;
   assign aer_valid = valid_q;
   assign aer_addr  = addr_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_iaf_spike_arbiter.sv
// Self-checking bench for iaf_spike_arbiter: expected AER addresses queued at stimulus, popped on transfer.
module tb_iaf_spike_arbiter;

   logic       clk = 1'b0;
   logic       rstb;
   logic [7:0] spike_in;
   logic       clear;
   logic [7:0] re_out;
   logic       aer_valid;
   logic [2:0] aer_addr;
   logic       aer_ready;
   logic       overflow;
   logic [7:0] drop_count;

`ifdef IAF_ARB_DROP_COUNT_EN
   localparam logic [7:0] DROP_ONE = 8'd1;
`else
   localparam logic [7:0] DROP_ONE = 8'd0;
`endif

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];
   logic [2:0] e;

   iaf_spike_arbiter #(.NEURONS(8), .ADDR_W(3)) dut (
      .clk(clk), .rstb(rstb), .spike_in(spike_in), .clear(clear), .re_out(re_out),
      .aer_valid(aer_valid), .aer_addr(aer_addr), .aer_ready(aer_ready),
      .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rstb = 1'b0; spike_in = 8'hFF; clear = 1'b0; aer_ready = 1'b1;
      tick(); tick();
      checks++;
      if ({re_out, aer_valid, aer_addr, overflow, drop_count} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs re=%h v=%b a=%0d ov=%b dc=%0d want all zero", re_out, aer_valid, aer_addr, overflow, drop_count);
      end
      rstb = 1'b1; spike_in = 8'h00;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (aer_valid !== 1'b0 || re_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle cycle %0d v=%b re=%h want v=0 re=00", k, aer_valid, re_out);
         end
      end
   endtask

   task automatic test_single();
      spike_in = 8'h20;
      tick();
      checks++;
      if (re_out !== 8'h20 || aer_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_re re=%h v=%b want re=20 v=0", re_out, aer_valid);
      end
      spike_in = 8'h00;
      tick();
      checks++;
      if (aer_valid !== 1'b1 || aer_addr !== 3'd5 || re_out !== 8'h00) begin
         errors++;
         $display("FAIL single_grant v=%b a=%0d re=%h want v=1 a=5 re=00", aer_valid, aer_addr, re_out);
      end
      tick();
      checks++;
      if (aer_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_empty v=%b want 0", aer_valid);
      end
   endtask

   task automatic test_ordering();
      logic [7:0] pats [2];
      pats[0] = 8'b1000_0101;
      pats[1] = 8'h81;
      do_clear();
      aer_ready = 1'b1;
      exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd7);
      exp_q.push_back(3'd0); exp_q.push_back(3'd7);
      for (int p = 0; p < 2; p++) begin
         spike_in = pats[p];
         tick();
         spike_in = 8'h00;
         for (int k = 0; k < 6; k++) begin
            if (aer_valid && aer_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL order_extra got addr %0d want no event", aer_addr);
               end else begin
                  e = exp_q.pop_front();
                  if (aer_addr !== e) begin
                     errors++;
                     $display("FAIL order_addr got %0d want %0d", aer_addr, e);
                  end
               end
            end
            tick();
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL order_missing %0d events not seen want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_backpressure();
      aer_ready = 1'b0;
      spike_in = 8'h08; tick();
      spike_in = 8'h00; tick();
      checks++;
      if (aer_valid !== 1'b1 || aer_addr !== 3'd3) begin
         errors++;
         $display("FAIL bp_present v=%b a=%0d want v=1 a=3", aer_valid, aer_addr);
      end
      spike_in = 8'h08; tick();
      checks++;
      if (aer_valid !== 1'b1 || aer_addr !== 3'd3 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold1 v=%b a=%0d ov=%b want v=1 a=3 ov=0", aer_valid, aer_addr, overflow);
      end
      spike_in = 8'h00; tick();
      spike_in = 8'h08; tick();
      spike_in = 8'h00;
      checks++;
      if (aer_valid !== 1'b1 || aer_addr !== 3'd3 || overflow !== 1'b1 || drop_count !== DROP_ONE) begin
         errors++;
         $display("FAIL bp_drop v=%b a=%0d ov=%b dc=%0d want v=1 a=3 ov=1 dc=%0d", aer_valid, aer_addr, overflow, drop_count, DROP_ONE);
      end
      // presented event plus the still-pending re-fire of neuron 3
      exp_q.push_back(3'd3); exp_q.push_back(3'd3);
      aer_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (aer_valid && aer_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra got addr %0d want no event", aer_addr);
            end else begin
               e = exp_q.pop_front();
               if (aer_addr !== e) begin
                  errors++;
                  $display("FAIL bp_addr got %0d want %0d", aer_addr, e);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL bp_end missing=%0d ov=%b want missing=0 ov=1", exp_q.size(), overflow);
         exp_q.delete();
      end
   endtask

   task automatic test_fairness();
      do_clear();
      aer_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(3'd1); exp_q.push_back(3'd6);
      end
      spike_in = 8'h42;
      tick();
      // each neuron re-fires on the edge it is granted, so both stay pending without drops
      for (int k = 0; k < 14; k++) begin
         spike_in = (k >= 8) ? 8'h00 : ((k % 2 == 0) ? 8'h02 : 8'h40);
         if (aer_valid && aer_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL fair_extra got addr %0d want no event", aer_addr);
            end else begin
               e = exp_q.pop_front();
               if (aer_addr !== e) begin
                  errors++;
                  $display("FAIL fair_addr got %0d want %0d", aer_addr, e);
               end
            end
         end
         tick();
      end
      spike_in = 8'h00;
      checks++;
      if (exp_q.size() != 0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fair_end missing=%0d ov=%b want missing=0 ov=0", exp_q.size(), overflow);
         exp_q.delete();
      end
   endtask

   task automatic test_clear();
      aer_ready = 1'b0;
      spike_in = 8'h0F; tick();
      spike_in = 8'h0E; tick();
      spike_in = 8'h00;
      checks++;
      if (aer_valid !== 1'b1 || aer_addr !== 3'd0 || overflow !== 1'b1 || drop_count !== DROP_ONE) begin
         errors++;
         $display("FAIL clr_pre v=%b a=%0d ov=%b dc=%0d want v=1 a=0 ov=1 dc=%0d", aer_valid, aer_addr, overflow, drop_count, DROP_ONE);
      end
      clear = 1'b1; aer_ready = 1'b1; spike_in = 8'h10;
      tick();
      clear = 1'b0; spike_in = 8'h00;
      checks++;
      if (aer_valid !== 1'b0 || overflow !== 1'b0 || re_out !== 8'hFF || drop_count !== 8'd0) begin
         errors++;
         $display("FAIL clr_now v=%b ov=%b re=%h dc=%0d want v=0 ov=0 re=FF dc=0", aer_valid, overflow, re_out, drop_count);
      end
      tick();
      checks++;
      if (re_out !== 8'h00) begin
         errors++;
         $display("FAIL clr_re_after re=%h want 00", re_out);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (aer_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_leak got addr %0d want no event", aer_addr);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ordering();
      test_backpressure();
      test_fairness();
      test_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
